// File: rtl/qspi_psram_fe_if.sv
// rtl/qspi_psram_fe_if.sv - QPI pin and nibble-RAM port bundle for the PSRAM front end
interface qspi_psram_fe_if;
    logic        qspi_sck;
    logic        qspi_ce_n;
    logic [3:0]  sio_in;
    logic [3:0]  sio_out;
    logic        sio_oe;
    logic [16:0] ram_radr;
    logic [3:0]  ram_rdata;
    logic [16:0] ram_wadr;
    logic [3:0]  ram_wdata;
    logic        ram_wen;

    modport master (
        output qspi_sck, qspi_ce_n, sio_in, ram_rdata,
        input  sio_out, sio_oe, ram_radr, ram_wadr, ram_wdata, ram_wen
    );

    modport slave (
        input  qspi_sck, qspi_ce_n, sio_in, ram_rdata,
        output sio_out, sio_oe, ram_radr, ram_wadr, ram_wdata, ram_wen
    );
endinterface

// File: rtl/qspi_psram_fe.sv
// rtl/qspi_psram_fe.sv - QSPI PSRAM device-model front end on oversampled QPI pins
// Optional QSPI_WRAP1K_EN: pointer wraps within bits [10:0] (1 KB burst page).
module qspi_psram_fe #(
    parameter int         DUMMY_CYC   = 6,
    parameter logic [7:0] CMD_WRITE   = 8'h38,
    parameter logic [7:0] CMD_READ    = 8'hEB,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    qspi_psram_fe_if.slave    bus
);
    localparam int CNT_MAX = (DUMMY_CYC > 6) ? DUMMY_CYC : 6;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ce_sync;
    logic [3:0]             sio_sync [SYNC_STAGES];
    logic                   sck_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            ce_sync  <= '1;
            sck_d    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sio_sync[i] <= 4'h0;
        end else begin
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], bus.qspi_sck};
            ce_sync     <= {ce_sync[SYNC_STAGES-2:0], bus.qspi_ce_n};
            sck_d       <= sck_sync[SYNC_STAGES-1];
            sio_sync[0] <= bus.sio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sio_sync[i] <= sio_sync[i-1];
        end
    end

    logic       sck_s, ce_s, rise, fall;
    logic [3:0] sio_s;

    // sio is taken from the same stage as sck so a nibble lines up with its edge
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ce_s  = ce_sync[SYNC_STAGES-1];
    assign sio_s = sio_sync[SYNC_STAGES-1];
    assign rise  = sck_s & ~sck_d;
    assign fall  = ~sck_s & sck_d;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_read;
    logic [3:0]    op_hi;
    logic [11:0]   addr_sh;
    logic [16:0]   ptr, ptr_next;
    logic [16:0]   radr_q, wadr_q;
    logic [3:0]    wdata_q, sio_out_q;
    logic          wen_q, sio_oe_q;

`ifdef QSPI_WRAP1K_EN
    assign ptr_next = {ptr[16:11], ptr[10:0] + 11'd1};
`else
    assign ptr_next = ptr + 17'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_read   <= 1'b0;
            op_hi     <= 4'h0;
            addr_sh   <= 12'h0;
            ptr       <= 17'h0;
            radr_q    <= 17'h0;
            wadr_q    <= 17'h0;
            wdata_q   <= 4'h0;
            wen_q     <= 1'b0;
            sio_out_q <= 4'h0;
            sio_oe_q  <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            // Deselect overrides any edge seen in the same clk
            if (ce_s) begin
                state    <= IDLE;
                cnt      <= '0;
                sio_oe_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= CMD;
                        cnt   <= '0;
                    end
                    CMD: if (rise) begin
                        op_hi <= sio_s;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(1)) begin
                            cnt <= '0;
                            if ({op_hi, sio_s} == CMD_WRITE) begin
                                is_read <= 1'b0;
                                state   <= ADDR;
                            end else if ({op_hi, sio_s} == CMD_READ) begin
                                is_read <= 1'b1;
                                state   <= ADDR;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    // Only the low 16 address bits survive; the top byte shifts out
                    ADDR: if (rise) begin
                        addr_sh <= {addr_sh[7:0], sio_s};
                        cnt     <= cnt + 1'b1;
                        if (cnt == CW'(5)) begin
                            ptr   <= {addr_sh, sio_s, 1'b0};
                            cnt   <= '0;
                            state <= is_read ? DUMMY : WDATA;
                        end
                    end
                    DUMMY: if (rise) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(DUMMY_CYC - 1)) begin
                            radr_q <= ptr;
                            state  <= RDATA;
                        end
                    end
                    RDATA: if (fall) begin
                        sio_out_q <= bus.ram_rdata;
                        sio_oe_q  <= 1'b1;
                        ptr       <= ptr_next;
                        radr_q    <= ptr_next;
                    end
                    WDATA: if (rise) begin
                        wen_q   <= 1'b1;
                        wadr_q  <= ptr;
                        wdata_q <= sio_s;
                        ptr     <= ptr_next;
                    end
                    IGNORE: sio_oe_q <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sio_out   = sio_out_q;
    assign bus.sio_oe    = sio_oe_q;
    assign bus.ram_radr  = radr_q;
    assign bus.ram_wadr  = wadr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_wen   = wen_q;
endmodule
